alarme_sequenciador: RTL and testbench
======================================

Name: alarme_sequenciador

Overview:
Arming and disarming sequencer for the house alarm. It takes the remote-control key (cr), three sensor zones (sm = motion, sp = door, sj = window) and a prescaled time-base pulse. It runs exit delay, entry delay, siren timeout and re-trigger. It drives the siren, status LED and an armed flag, and sits between the raw pad/sensor inputs and the siren/LED drivers.

Parameters:
EXIT_TICKS, 8, ticks of exit delay after arming (legal range 1..255)
ENTRY_TICKS, 6, ticks of entry delay after a door event while armed (1..255)
SIREN_TICKS, 20, ticks the siren sounds per trigger (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cr  input  1  remote-control key, asynchronous level; each rising edge is one press
sm  input  1  motion sensor, asynchronous, active-high, instant zone
sp  input  1  door sensor, asynchronous, active-high, delayed zone
sj  input  1  window sensor, asynchronous, active-high, instant zone
tick  input  1  synchronous one-cycle time-base pulse
sirene  output  1  siren drive, registered
led  output  1  status LED, registered
armado  output  1  high in any state other than DESARMADO, registered
zona  output  3  first-tripped zone memory {sj,sp,sm}; see Optional Feature

Behaviour:
- Reset (reset = 0, asynchronous): state is DESARMADO; sirene = 0, led = 0, armado = 0, zona = 000; counter = 0; all synchronizer flops = 0.
- cr, sm, sp and sj each pass through a 2-flop synchronizer. A press is cr_s & ~cr_prev.
  - The state changes on the 3rd rising edge counting the edge that first samples cr = 1.
  - Sensors use the synchronized level, so they have 2 cycles of latency.
- Counter: 8-bit down-counter.
  - It is loaded on the edge that enters a timed state (SAIDA, ENTRADA, DISPARO).
  - It decrements only on tick. A load wins over a coincident tick.
  - Expiry is tick while counter == 1; the transition happens on that edge. The counter never wraps below 0.
- Priority in every state: press > instant zone (sm | sj) > door (sp) > expiry.
- DESARMADO: sirene 0, led 0. Press -> SAIDA (load EXIT_TICKS). Sensors are ignored.
- SAIDA: sirene 0, led toggles on each tick. Press -> DESARMADO. Expiry -> ARMADO. Sensors are ignored.
- ARMADO: sirene 0, led steady 1. Transitions:
  - Press -> DESARMADO.
  - sm | sj -> DISPARO (load SIREN_TICKS).
  - sp -> ENTRADA (load ENTRY_TICKS).
- ENTRADA: sirene 0, led toggles on each tick. Transitions:
  - Press -> DESARMADO.
  - sm | sj -> DISPARO.
  - Expiry -> DISPARO.
  - sp deasserting does not cancel the entry delay.
- DISPARO: sirene 1, led toggles on each tick. Press -> DESARMADO. Expiry -> SILENCIO.
- SILENCIO: sirene 0, led steady 1.
  - A rising edge of any synchronized sensor -> DISPARO (reload SIREN_TICKS). A sensor held high since DISPARO does not re-trigger.
  - Press -> DESARMADO.
- On every entry to DESARMADO: sirene = 0 and led = 0 on the same edge.
- armado = (next state != DESARMADO), registered with the state.
- led is cleared to 0 on entry to SAIDA, ENTRADA and DISPARO so the toggle phase is deterministic.
- Reset asserted mid-sequence: all outputs return to their reset values immediately, without waiting for clk.

Optional Feature:
ALARME_MEMORIA_EN
- Defined:
  - On the edge that enters ENTRADA or DISPARO from ARMADO, zona captures {sj_s, sp_s, sm_s}.
  - zona holds through ENTRADA, DISPARO and SILENCIO.
  - Later trips and re-triggers do not overwrite it.
  - zona is cleared on the next press that arms the system (DESARMADO -> SAIDA) and on reset. Disarming does not clear it, so the trip zone stays readable.
- Not defined: zona is constant 000 and the capture logic is absent.

Test Plan:
- Press cr with EXIT_TICKS=8, then 8 ticks -> SAIDA with led toggling; after the 8th tick armado = 1, led = 1, sirene = 0.
- Armed; sp = 1 for 1 cycle, then 6 ticks -> ENTRADA; sirene rises on the edge of the 6th tick. With ALARME_MEMORIA_EN, zona = 010.
- Armed; sp = 1, then a press after 3 ticks -> DESARMADO; sirene never asserts; armado = 0.
- Armed; sj = 1 held -> DISPARO 2 cycles after sj; after 20 ticks -> SILENCIO, sirene = 0. Still held: no re-trigger. Drop sj, then sm = 1 -> DISPARO with a fresh 20 ticks.
- In SAIDA, tick coincident with the load edge -> ignored; exit still takes exactly EXIT_TICKS further ticks. Press and sm on the same cycle in ARMADO -> DESARMADO.
- reset = 0 between clock edges during DISPARO -> sirene = 0, led = 0, armado = 0, zona = 000 immediately.

Source files
------------

// File: rtl/alarme_sequenciador.sv
// House-alarm arming sequencer: exit/entry delays, siren timeout and re-trigger.
// Optional first-tripped zone memory is enabled by defining ALARME_MEMORIA_EN.
module alarme_sequenciador #(
    parameter int EXIT_TICKS  = 8,
    parameter int ENTRY_TICKS = 6,
    parameter int SIREN_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cr,
    input  logic       sm,
    input  logic       sp,
    input  logic       sj,
    input  logic       tick,
    output logic       sirene,
    output logic       led,
    output logic       armado,
    output logic [2:0] zona
);

    typedef enum logic [2:0] {
        DESARMADO,
        SAIDA,
        ARMADO,
        ENTRADA,
        DISPARO,
        SILENCIO
    } state_t;

    localparam logic [7:0] L_EXIT  = 8'(EXIT_TICKS);
    localparam logic [7:0] L_ENTRY = 8'(ENTRY_TICKS);
    localparam logic [7:0] L_SIREN = 8'(SIREN_TICKS);

    state_t     r_state;
    logic [3:0] r_syncMeta;
    logic [3:0] r_syncOut;
    logic       r_crPrev;
    logic [2:0] r_sensPrev;
    logic [7:0] r_count;
    logic       r_sirene;
    logic       r_led;
    logic       r_armado;

    state_t     w_nextState;
    logic       w_load;
    logic [7:0] w_loadVal;
    logic       w_nextLed;
    logic [7:0] w_nextCount;
    logic       w_press;
    logic       w_instant;
    logic       w_door;
    logic [2:0] w_sensRise;
    logic       w_expire;
    logic       w_nextTimed;

    // Synchronizer bit order is {cr, sj, sp, sm} so [2:0] matches the zona layout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_syncMeta <= 4'b0000;
            r_syncOut  <= 4'b0000;
            r_crPrev   <= 1'b0;
            r_sensPrev <= 3'b000;
        end else begin
            r_syncMeta <= {cr, sj, sp, sm};
            r_syncOut  <= r_syncMeta;
            r_crPrev   <= r_syncOut[3];
            r_sensPrev <= r_syncOut[2:0];
        end
    end

    assign w_press    = r_syncOut[3] & ~r_crPrev;
    assign w_instant  = r_syncOut[0] | r_syncOut[2];
    assign w_door     = r_syncOut[1];
    assign w_sensRise = r_syncOut[2:0] & ~r_sensPrev;
    assign w_expire   = tick & (r_count == 8'd1);

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadVal   = 8'd0;
        case (r_state)
            DESARMADO: begin
                if (w_press) begin
                    w_nextState = SAIDA;
                    w_load      = 1'b1;
                    w_loadVal   = L_EXIT;
                end
            end
            SAIDA: begin
                if (w_press)       w_nextState = DESARMADO;
                else if (w_expire) w_nextState = ARMADO;
            end
            ARMADO: begin
                if (w_press) begin
                    w_nextState = DESARMADO;
                end else if (w_instant) begin
                    w_nextState = DISPARO;
                    w_load      = 1'b1;
                    w_loadVal   = L_SIREN;
                end else if (w_door) begin
                    w_nextState = ENTRADA;
                    w_load      = 1'b1;
                    w_loadVal   = L_ENTRY;
                end
            end
            ENTRADA: begin
                if (w_press) begin
                    w_nextState = DESARMADO;
                end else if (w_instant || w_expire) begin
                    w_nextState = DISPARO;
                    w_load      = 1'b1;
                    w_loadVal   = L_SIREN;
                end
            end
            DISPARO: begin
                if (w_press)       w_nextState = DESARMADO;
                else if (w_expire) w_nextState = SILENCIO;
            end
            SILENCIO: begin
                if (w_press) begin
                    w_nextState = DESARMADO;
                end else if (|w_sensRise) begin
                    w_nextState = DISPARO;
                    w_load      = 1'b1;
                    w_loadVal   = L_SIREN;
                end
            end
            default: w_nextState = DESARMADO;
        endcase
    end

    // Every entry into a timed state goes through a load, which also zeroes the LED phase.
    always_comb begin
        w_nextTimed = (w_nextState == SAIDA) || (w_nextState == ENTRADA) ||
                      (w_nextState == DISPARO);
        w_nextLed   = 1'b0;
        w_nextCount = r_count;
        if (w_nextState == ARMADO || w_nextState == SILENCIO) begin
            w_nextLed = 1'b1;
        end else if (w_nextTimed) begin
            if (w_load)    w_nextLed = 1'b0;
            else if (tick) w_nextLed = ~r_led;
            else           w_nextLed = r_led;
        end
        if (w_load) begin
            w_nextCount = w_loadVal;
        end else if (!w_nextTimed) begin
            w_nextCount = 8'd0;
        end else if (tick && r_count != 8'd0) begin
            w_nextCount = r_count - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= DESARMADO;
            r_count  <= 8'd0;
            r_sirene <= 1'b0;
            r_led    <= 1'b0;
            r_armado <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_sirene <= (w_nextState == DISPARO);
            r_led    <= w_nextLed;
            r_armado <= (w_nextState != DESARMADO);
        end
    end

`ifdef ALARME_MEMORIA_EN
    logic [2:0] r_zona;

    // Only the first trip out of ARMADO is remembered; disarming keeps it readable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zona <= 3'b000;
        end else if (r_state == DESARMADO && w_nextState == SAIDA) begin
            r_zona <= 3'b000;
        end else if (r_state == ARMADO &&
                     (w_nextState == ENTRADA || w_nextState == DISPARO)) begin
            r_zona <= r_syncOut[2:0];
        end
    end

    assign zona = r_zona;
`else
    assign zona = 3'b000;
`endif

    assign sirene = r_sirene;
    assign led    = r_led;
    assign armado = r_armado;

endmodule

// File: tb/tb_alarme_sequenciador.sv
// Directed bench for alarme_sequenciador with default timing parameters.
// Zone expectations follow ALARME_MEMORIA_EN when it is defined for the build.
module tb_alarme_sequenciador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cr = 1'b0;
    logic       sm = 1'b0;
    logic       sp = 1'b0;
    logic       sj = 1'b0;
    logic       tick = 1'b0;
    logic       sirene;
    logic       led;
    logic       armado;
    logic [2:0] zona;

    int checks = 0;
    int errors = 0;

`ifdef ALARME_MEMORIA_EN
    localparam bit MEM = 1'b1;
`else
    localparam bit MEM = 1'b0;
`endif

    alarme_sequenciador #(
        .EXIT_TICKS (8),
        .ENTRY_TICKS(6),
        .SIREN_TICKS(20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cr    (cr),
        .sm    (sm),
        .sp    (sp),
        .sj    (sj),
        .tick  (tick),
        .sirene(sirene),
        .led   (led),
        .armado(armado),
        .zona  (zona)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pressKey();
        cr = 1'b1;
        cyc(3);
        cr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic eSir, input logic eLed,
                               input logic eArm, input logic [2:0] eZona);
        logic [2:0] z;
        z = MEM ? eZona : 3'b000;
        checks++;
        assert (sirene === eSir) else begin
            errors++;
            $error("FAIL %s sirene got %0b exp %0b", tag, sirene, eSir);
        end
        checks++;
        assert (led === eLed) else begin
            errors++;
            $error("FAIL %s led got %0b exp %0b", tag, led, eLed);
        end
        checks++;
        assert (armado === eArm) else begin
            errors++;
            $error("FAIL %s armado got %0b exp %0b", tag, armado, eArm);
        end
        checks++;
        assert (zona === z) else begin
            errors++;
            $error("FAIL %s zona got %b exp %b", tag, zona, z);
        end
    endtask

    initial begin
        #1;
        checkOutput("reset", 0, 0, 0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);

        // First press: state must change on the third edge after cr rises.
        cr = 1'b1;
        cyc(2);
        checkOutput("press_edge2", 0, 0, 0, 3'b000);
        cyc(1);
        checkOutput("saida_entry", 0, 0, 1, 3'b000);
        cr = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus();
            checkOutput("saida_tick", 0, logic'(k % 2), 1, 3'b000);
        end
        sp = 1'b1;
        cyc(3);
        checkOutput("saida_ignores_sp", 0, 1, 1, 3'b000);
        sp = 1'b0;
        cyc(3);
        applyStimulus();
        checkOutput("armado", 0, 1, 1, 3'b000);
        applyStimulus();
        checkOutput("armado_steady", 0, 1, 1, 3'b000);

        // Door pulse starts the entry delay; siren on the sixth tick.
        sp = 1'b1;
        cyc(1);
        sp = 1'b0;
        cyc(2);
        checkOutput("entrada", 0, 0, 1, 3'b010);
        for (int k = 1; k <= 5; k++) applyStimulus();
        checkOutput("entrada_t5", 0, 1, 1, 3'b010);
        applyStimulus();
        checkOutput("disparo_from_entry", 1, 0, 1, 3'b010);
        pressKey();
        checkOutput("disarm_from_disparo", 0, 0, 0, 3'b010);
        cyc(3);

        // Re-arm clears the zone; door then press during entry aborts.
        pressKey();
        checkOutput("rearm_clears_zona", 0, 0, 1, 3'b000);
        for (int k = 1; k <= 8; k++) applyStimulus();
        checkOutput("armado2", 0, 1, 1, 3'b000);
        sp = 1'b1;
        cyc(1);
        sp = 1'b0;
        cyc(2);
        checkOutput("entrada2", 0, 0, 1, 3'b010);
        for (int k = 1; k <= 3; k++) applyStimulus();
        checkOutput("entrada2_t3", 0, 1, 1, 3'b010);
        pressKey();
        checkOutput("abort_entry", 0, 0, 0, 3'b010);
        for (int k = 1; k <= 6; k++) applyStimulus();
        checkOutput("abort_no_siren", 0, 0, 0, 3'b010);
        cyc(2);

        // Window held: trip, timeout, no re-trigger while held, then motion re-trigger.
        pressKey();
        checkOutput("arm3", 0, 0, 1, 3'b000);
        for (int k = 1; k <= 8; k++) applyStimulus();
        checkOutput("armado3", 0, 1, 1, 3'b000);
        sj = 1'b1;
        cyc(2);
        checkOutput("sj_latency", 0, 1, 1, 3'b000);
        cyc(1);
        checkOutput("disparo_sj", 1, 0, 1, 3'b100);
        for (int k = 1; k <= 19; k++) applyStimulus();
        checkOutput("disparo_t19", 1, 1, 1, 3'b100);
        applyStimulus();
        checkOutput("silencio", 0, 1, 1, 3'b100);
        cyc(5);
        applyStimulus();
        checkOutput("no_retrigger", 0, 1, 1, 3'b100);
        sj = 1'b0;
        cyc(3);
        sm = 1'b1;
        cyc(3);
        checkOutput("retrigger_sm", 1, 0, 1, 3'b100);
        for (int k = 1; k <= 19; k++) applyStimulus();
        checkOutput("retrigger_t19", 1, 1, 1, 3'b100);
        applyStimulus();
        checkOutput("silencio2", 0, 1, 1, 3'b100);
        sm = 1'b0;
        cyc(3);
        pressKey();
        checkOutput("disarm4", 0, 0, 0, 3'b100);
        cyc(3);

        // Tick on the load edge is ignored; exit still needs eight more ticks.
        cr = 1'b1;
        cyc(2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cr = 1'b0;
        checkOutput("load_beats_tick", 0, 0, 1, 3'b000);
        for (int k = 1; k <= 7; k++) applyStimulus();
        checkOutput("exit_t7", 0, 1, 1, 3'b000);
        sp = 1'b1;
        cyc(3);
        checkOutput("exit_holds_t7", 0, 1, 1, 3'b000);
        sp = 1'b0;
        cyc(3);
        applyStimulus();
        checkOutput("exit_t8", 0, 1, 1, 3'b000);
        cr = 1'b1;
        sm = 1'b1;
        cyc(3);
        checkOutput("press_beats_sm", 0, 0, 0, 3'b000);
        cr = 1'b0;
        cyc(3);
        checkOutput("desarmado_ignores_sm", 0, 0, 0, 3'b000);
        sm = 1'b0;
        cyc(3);

        // Asynchronous reset in the middle of DISPARO.
        pressKey();
        for (int k = 1; k <= 8; k++) applyStimulus();
        sj = 1'b1;
        cyc(1);
        sj = 1'b0;
        cyc(2);
        checkOutput("disparo_pre_reset", 1, 0, 1, 3'b100);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        checkOutput("after_reset", 0, 0, 0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
